uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DW, default 8: data width, bits per character.
REQ-002 Parameter PT, default "NONE": parity type, one of "EVEN", "ODD" or "NONE".
REQ-003 Parameter SW, default 1: number of stop bits (1 or 2).
REQ-004 Parameter BN, default 2: clock periods per UART bit; BN >= 2.
REQ-005 Parameter BL, default $clog2(BN): width of the baud counter.
REQ-006 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port str_tvalid, input, 1: transmit stream data valid.
REQ-009 Port str_tdata, input, DW: transmit stream data.
REQ-010 Port str_tready, output, 1: transmitter accepts a character.
REQ-011 Port busy, output, 1: a frame is in progress.
REQ-012 Port uart_txd, output, 1: serial line; idle level is 1.

Function
REQ-013 A transfer SHALL occur on any rising edge where str_tvalid & str_tready = 1; str_tdata is captured into a DW-bit shift register on that edge.
REQ-014 str_tready SHALL equal 1 only in state IDLE; it is registered or decoded from state and never depends combinationally on str_tvalid.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP, with these transitions:
- IDLE->START on transfer.
- START->DATA after BN cycles.
- DATA->PARITY after DW bit periods if PT!="NONE", else DATA->STOP.
- PARITY->STOP after one bit period.
- STOP->IDLE after SW bit periods.
REQ-016 uart_txd SHALL be registered, with these levels:
- IDLE: 1.
- START: 0.
- DATA: shift register bit 0; data is sent LSB first and shifted right once per bit period.
- PARITY: parity bit.
- STOP: 1.
REQ-017 uart_txd SHALL fall on the first rising edge after the transfer edge (latency 1 cycle), and each bit SHALL last exactly BN cycles.
REQ-018 Parity bit SHALL be the XOR of the DW data bits for "EVEN" and the inverted XOR for "ODD"; it is computed from the captured data, not from the live str_tdata.
REQ-019 A BL-bit baud counter SHALL load BN-1 at frame start and at each bit boundary, and decrement to 0; the bit boundary is the cycle in which the counter is 0.
REQ-020 A 4-bit bit counter SHALL track remaining DATA and STOP bits; total frame length is TW = 1+DW+(PT!="NONE")+SW bits.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 The frame SHALL occupy TW*BN cycles from the first low uart_txd cycle; the FSM returns to IDLE with str_tready=1 on the cycle after the last stop-bit cycle.
REQ-023 Minimum start-edge-to-start-edge spacing for back-to-back characters SHALL be TW*BN+1 cycles.
REQ-024 Changes on str_tvalid or str_tdata while str_tready=0 SHALL have no effect on the frame in progress.
REQ-025 str_tvalid held high in IDLE SHALL cause exactly one transfer per IDLE visit.

Reset
REQ-026 On rst=1, asynchronously and regardless of frame progress:
- state=IDLE, uart_txd=1, busy=0, str_tready=1.
- baud counter=BN-1, bit counter=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately; the line returns high with no partial stop bit and no character is retransmitted after release.
REQ-028 The data shift register needs no reset.

Structure
REQ-029 A shared package uart_pkg SHALL hold:
- the parity type string constants;
- a TW(DW,PT,SW) width function;
- the FSM state enumeration (also usable by uart_rx).
REQ-030 The baud counter SHALL be a sub-module uart_baud with inputs clk, rst, load and enable, and output tick; the shift register, parity and FSM stay in uart_tx.
REQ-031 The implementation SHALL be in the 120-400 line range, with no latches and a single clock domain.

Verification
REQ-032 DW=8, PT="NONE", SW=1, BN=4; send 0x55 -> uart_txd 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; str_tready low for 40 cycles.
REQ-033 PT="EVEN", send 0x07 -> parity bit 1; PT="ODD", send 0x07 -> parity bit 0; PT="EVEN", send 0x00 -> parity bit 0.
REQ-034 str_tvalid held high with 0xA5 then 0x3C, BN=4, TW=10 -> two frames, falling start edges 41 cycles apart, data LSB first correct.
REQ-035 SW=2 -> stop-high period of 8 cycles at BN=4; str_tdata changed mid-frame -> transmitted byte unchanged.
REQ-036 rst pulsed during DATA bit 3 -> uart_txd=1, busy=0, str_tready=1 in the same cycle; the next transfer after release produces a complete correct frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity type constants, frame width helper,
// FSM state encoding and the parity calculation used by the transmitter.
package uart_pkg;

   // Parity type codes, compared against the 32-bit PT parameter
   localparam logic [31:0] PT_NONE = "NONE";
   localparam logic [31:0] PT_EVEN = "EVEN";
   localparam logic [31:0] PT_ODD  = {8'h00, "ODD"};

   // Frame states, shared by transmitter and receiver
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Total frame length in bits: start + data + optional parity + stop bits
   function automatic int unsigned uart_tw(input int unsigned dw,
                                           input logic [31:0]  pt,
                                           input int unsigned sw);
      int unsigned par;
      if (pt != PT_NONE) begin
         par = 32'd1;
      end else begin
         par = 32'd0;
      end
      return 32'd1 + dw + par + sw;
   endfunction

   // Parity over up to 16 data bits (unused upper bits must be zero);
   // odd=1 inverts the XOR so the total count of ones becomes odd
   function automatic logic uart_parity(input logic [15:0] data,
                                        input logic        odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud.sv
// Baud-rate divider: down-counter that reloads BN-1 on load and flags the
// last cycle of each bit period with tick while enabled.
module uart_baud #(
   parameter int BN = 2,
   parameter int BL = $clog2(BN)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic tick
);

   localparam logic [BL-1:0] RELOAD = BL'(BN - 1);

   logic [BL-1:0] cnt_q;
   logic [BL-1:0] cnt_d;

   // Next count: reload has priority, otherwise count down while enabled
   always_comb begin
      if (load) begin
         cnt_d = RELOAD;
      end else if (enable) begin
         cnt_d = cnt_q - BL'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register, parked at the reload value in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable & (cnt_q == {BL{1'b0}});

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one character per IDLE visit from a valid/ready
// stream and serialises start, LSB-first data, optional parity and stop bits.
// The line register follows the FSM state with one cycle of latency.
module uart_tx
   import uart_pkg::*;
#(
   parameter int          DW = 8,
   parameter logic [31:0] PT = PT_NONE,
   parameter int          SW = 1,
   parameter int          BN = 2,
   parameter int          BL = $clog2(BN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          str_tvalid,
   input  logic [DW-1:0] str_tdata,
   output logic          str_tready,
   output logic          busy,
   output logic          uart_txd
);

   localparam logic HAS_PAR = (PT != PT_NONE);
   localparam logic ODD_PAR = (PT == PT_ODD);

   uart_state_e   state_q, state_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          busy_q, busy_d;
   logic          rdy_q, rdy_d;
   logic          xfer;
   logic          tick;
   logic          baud_load;
   logic          baud_en;

   assign xfer      = str_tvalid & rdy_q;
   assign baud_load = xfer | tick;
   assign baud_en   = (state_q != ST_IDLE);

   uart_baud #(
      .BN (BN),
      .BL (BL)
   ) u_baud (
      .clk    (clk),
      .rst    (rst),
      .load   (baud_load),
      .enable (baud_en),
      .tick   (tick)
   );

   // State and registered outputs; reset forces an idle, ready line at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= 4'd0;
         par_q    <= 1'b0;
         txd_q    <= 1'b1;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         par_q    <= par_d;
         txd_q    <= txd_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
      end
   end

   // Character shift register; its contents are don't-care until loaded
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   // Next-state logic; every move happens on a bit boundary except leaving IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick && (bitcnt_q == 4'd0)) begin
               state_d = HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end else begin
               state_d = ST_PARITY;
            end
         end
         ST_STOP: begin
            if (tick && (bitcnt_q == 4'd0)) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture, per-bit shifting, remaining-bit count and parity
   always_comb begin
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      par_d    = par_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               shreg_d = str_tdata;
            end else begin
               shreg_d = shreg_q;
            end
         end
         ST_START: begin
            if (tick) begin
               bitcnt_d = 4'(DW - 1);
               par_d    = uart_parity(16'(shreg_q), ODD_PAR);
            end else begin
               bitcnt_d = bitcnt_q;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_d = shreg_q >> 1;
               if (bitcnt_q == 4'd0) begin
                  bitcnt_d = 4'(SW - 1);
               end else begin
                  bitcnt_d = bitcnt_q - 4'd1;
               end
            end else begin
               shreg_d = shreg_q;
            end
         end
         ST_PARITY: begin
            bitcnt_d = bitcnt_q;
         end
         ST_STOP: begin
            if (tick && (bitcnt_q != 4'd0)) begin
               bitcnt_d = bitcnt_q - 4'd1;
            end else begin
               bitcnt_d = bitcnt_q;
            end
         end
         default: begin
            bitcnt_d = 4'd0;
         end
      endcase
   end

   // Output decode: line level from the current state, flags from the next
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != ST_IDLE);
      rdy_d  = (state_d == ST_IDLE);
      case (state_q)
         ST_IDLE:   txd_d = 1'b1;
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shreg_q[0];
         ST_PARITY: txd_d = par_q;
         ST_STOP:   txd_d = 1'b1;
         default:   txd_d = 1'b1;
      endcase
   end

   assign uart_txd   = txd_q;
   assign busy       = busy_q;
   assign str_tready = rdy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop
// bits) at BN=4, a vector table of single frames, plus back-to-back and
// mid-frame reset sequences.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int BN = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] tv;
   logic [7:0] td [4];
   logic [3:0] txd;
   logic [3:0] rdy;
   logic [3:0] bsy;
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.DW(8), .PT(PT_NONE), .SW(1), .BN(BN)) u0 (
      .clk(clk), .rst(rst), .str_tvalid(tv[0]), .str_tdata(td[0]),
      .str_tready(rdy[0]), .busy(bsy[0]), .uart_txd(txd[0]));
   uart_tx #(.DW(8), .PT(PT_EVEN), .SW(1), .BN(BN)) u1 (
      .clk(clk), .rst(rst), .str_tvalid(tv[1]), .str_tdata(td[1]),
      .str_tready(rdy[1]), .busy(bsy[1]), .uart_txd(txd[1]));
   uart_tx #(.DW(8), .PT(PT_ODD), .SW(1), .BN(BN)) u2 (
      .clk(clk), .rst(rst), .str_tvalid(tv[2]), .str_tdata(td[2]),
      .str_tready(rdy[2]), .busy(bsy[2]), .uart_txd(txd[2]));
   uart_tx #(.DW(8), .PT(PT_NONE), .SW(2), .BN(BN)) u3 (
      .clk(clk), .rst(rst), .str_tvalid(tv[3]), .str_tdata(td[3]),
      .str_tready(rdy[3]), .busy(bsy[3]), .uart_txd(txd[3]));

   typedef struct {
      int         u;
      logic [7:0] data;
      logic [11:0] exp;   // bit i = i-th transmitted line bit
      int         len;
      string      name;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Wait for the start bit on unit u, then sample every cycle of len bits
   task automatic recv(input int u, input int len, output logic [11:0] got,
                       output int lat, output int unstable, output int t_start,
                       output int busy_at_start);
      got = 12'h000;
      unstable = 0;
      lat = 0;
      @(negedge clk);
      while (txd[u] && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      t_start = cyc;
      busy_at_start = bsy[u];
      for (int i = 0; i < len; i++) begin
         for (int c = 0; c < BN; c++) begin
            if (i > 0 || c > 0) @(negedge clk);
            if (c == 0) got[i] = txd[u];
            else if (txd[u] != got[i]) unstable++;
         end
      end
   endtask

   task automatic send_and_check(input int u, input logic [7:0] data,
                                 input logic [11:0] exp, input int len,
                                 input string name);
      int n;
      int low_cnt;
      int lat;
      int unstable;
      int ts;
      int bstart;
      int idle_after;
      logic [11:0] got;
      n = 0;
      @(negedge clk);
      while (!rdy[u] && n < 200) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s ready", name), int'(rdy[u]), 1);
      tv[u] = 1'b1;
      td[u] = data;
      @(posedge clk);
      #1;
      tv[u] = 1'b0;
      td[u] = ~data;
      fork
         begin
            int m;
            m = 0;
            low_cnt = 0;
            @(negedge clk);
            while (!rdy[u] && m < 200) begin
               low_cnt++;
               m++;
               @(negedge clk);
            end
         end
         begin
            recv(u, len, got, lat, unstable, ts, bstart);
            @(negedge clk);
            idle_after = int'(txd[u]);
         end
      join
      check($sformatf("%s latency", name), lat, 1);
      check($sformatf("%s busy", name), bstart, 1);
      check($sformatf("%s frame", name), int'(got), int'(exp));
      check($sformatf("%s bit_width", name), unstable, 0);
      check($sformatf("%s idle_after", name), idle_after, 1);
      check($sformatf("%s tready_low", name), low_cnt, len * BN);
   endtask

   // Two characters with tvalid held high across both transfers
   task automatic back_to_back();
      int xfers;
      int n;
      int lat;
      int uns1;
      int uns2;
      int t1;
      int t2;
      int b;
      int lows;
      logic [11:0] g1;
      logic [11:0] g2;
      xfers = 0;
      n = 0;
      @(negedge clk);
      tv[0] = 1'b1;
      td[0] = 8'hA5;
      fork
         begin
            while (xfers < 2 && n < 300) begin
               if (tv[0] && rdy[0]) begin
                  @(posedge clk);
                  #1;
                  xfers++;
                  if (xfers == 1) td[0] = 8'h3C;
                  else tv[0] = 1'b0;
               end else begin
                  @(negedge clk);
                  n++;
               end
            end
         end
         begin
            recv(0, 10, g1, lat, uns1, t1, b);
            recv(0, 10, g2, lat, uns2, t2, b);
         end
      join
      tv[0] = 1'b0;
      check("b2b transfers", xfers, 2);
      check("b2b frame1", int'(g1), 12'h34A);
      check("b2b frame2", int'(g2), 12'h278);
      check("b2b bit_width", uns1 + uns2, 0);
      check("b2b spacing", t2 - t1, 41);
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (!txd[0]) lows++;
      end
      check("b2b no_third_frame", lows, 0);
   endtask

   // Reset pulse in the middle of data bit 3, then a clean frame
   task automatic reset_mid_frame();
      int n;
      int lows;
      n = 0;
      @(negedge clk);
      while (!rdy[0] && n < 200) begin
         @(negedge clk);
         n++;
      end
      tv[0] = 1'b1;
      td[0] = 8'hA5;
      @(posedge clk);
      #1;
      tv[0] = 1'b0;
      n = 0;
      @(negedge clk);
      while (txd[0] && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (17) @(negedge clk);
      check("rst_mid bit3_level", int'(txd[0]), 0);
      check("rst_mid busy_before", int'(bsy[0]), 1);
      rst = 1'b1;
      #1;
      check("rst_mid txd", int'(txd[0]), 1);
      check("rst_mid busy", int'(bsy[0]), 0);
      check("rst_mid tready", int'(rdy[0]), 1);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      repeat (50) begin
         @(negedge clk);
         if (!txd[0]) lows++;
      end
      check("rst_mid no_resend", lows, 0);
      send_and_check(0, 8'h5A, 12'h2B4, 10, "rst_mid after");
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{u: 0, data: 8'h55, exp: 12'h2AA, len: 10, name: "none_55"};
      vecs[1] = '{u: 1, data: 8'h07, exp: 12'h60E, len: 11, name: "even_07"};
      vecs[2] = '{u: 2, data: 8'h07, exp: 12'h40E, len: 11, name: "odd_07"};
      vecs[3] = '{u: 1, data: 8'h00, exp: 12'h400, len: 11, name: "even_00"};
      vecs[4] = '{u: 3, data: 8'hC3, exp: 12'h786, len: 11, name: "sw2_C3"};

      tv = 4'b0000;
      for (int i = 0; i < 4; i++) td[i] = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset txd u%0d", i), int'(txd[i]), 1);
         check($sformatf("reset busy u%0d", i), int'(bsy[i]), 0);
         check($sformatf("reset tready u%0d", i), int'(rdy[i]), 1);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         send_and_check(vecs[i].u, vecs[i].data, vecs[i].exp, vecs[i].len,
                        vecs[i].name);
      end

      back_to_back();
      reset_mid_frame();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
